// File: rtl/ps2_host_tx.sv
// Host-to-device PS/2 transmitter: inhibits the bus, issues a request-to-send,
// then shifts one command byte out on device-generated clock edges and checks the ack.
module ps2_host_tx #(
    parameter int CLK_HZ         = 100_000_000,
    parameter int INHIBIT_CYCLES = 10_000,
    parameter int TIMEOUT_CYCLES = 2_000_000
) (
    input  logic       clk,
    input  logic       reset,
    input  logic [7:0] tx_data,
    input  logic       tx_start,
    output logic       tx_busy,
    output logic       tx_done,
    output logic       tx_error,
    input  logic       ps2_clk_in,
    input  logic       ps2_data_in,
    output logic       ps2_clk_oe,
    output logic       ps2_data_oe
);

    if (CLK_HZ <= 0 || INHIBIT_CYCLES <= 0 || TIMEOUT_CYCLES <= 0) begin : g_bad_param
        $error("ps2_host_tx: CLK_HZ, INHIBIT_CYCLES and TIMEOUT_CYCLES must be positive");
    end

    localparam int INH_W = $clog2(INHIBIT_CYCLES + 1);
    localparam int TMO_W = $clog2(TIMEOUT_CYCLES + 1);

    localparam logic [INH_W-1:0] INH_LAST = INH_W'(INHIBIT_CYCLES - 1);
    localparam logic [INH_W-1:0] INH_MAX  = INH_W'(INHIBIT_CYCLES);
    localparam logic [TMO_W-1:0] TMO_MAX  = TMO_W'(TIMEOUT_CYCLES);

    typedef enum logic [2:0] {
        S_IDLE,
        S_INHIBIT,
        S_REQ,
        S_SEND,
        S_ACK,
        S_WAIT_REL,
        S_DONE
    } state_e;

    state_e           state_q;
    logic [8:0]       shift_q;
    logic [3:0]       bit_cnt_q;
    logic [INH_W-1:0] inh_cnt_q;
    logic [INH_W-1:0] inh_cnt_d;
    logic [TMO_W-1:0] tmo_cnt_q;
    logic [TMO_W-1:0] tmo_cnt_d;
    logic             clk_oe_q;
    logic             data_oe_q;
    logic             busy_q;
    logic             done_q;
    logic             error_q;

    logic [1:0]       clk_sync_q;
    logic [1:0]       data_sync_q;
    logic             clk_prev_q;
    logic             clk_s;
    logic             data_s;
    logic             fall;
    logic             tmo_hit;

    // NOTE: synchronizers reset to the idle-high bus level so leaving reset never looks like a falling edge.
    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            clk_sync_q  <= 2'b11;
            data_sync_q <= 2'b11;
            clk_prev_q  <= 1'b1;
        end else begin
            clk_sync_q  <= {clk_sync_q[0], ps2_clk_in};
            data_sync_q <= {data_sync_q[0], ps2_data_in};
            clk_prev_q  <= clk_sync_q[1];
        end
    end

    assign clk_s   = clk_sync_q[1];
    assign data_s  = data_sync_q[1];
    assign fall    = clk_prev_q & ~clk_s;

    assign inh_cnt_d = (inh_cnt_q == INH_MAX) ? inh_cnt_q : inh_cnt_q + 1'b1;
    assign tmo_cnt_d = (tmo_cnt_q == TMO_MAX) ? tmo_cnt_q : tmo_cnt_q + 1'b1;
    assign tmo_hit   = (tmo_cnt_q == TMO_MAX);

    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            state_q   <= S_IDLE;
            shift_q   <= '0;
            bit_cnt_q <= '0;
            inh_cnt_q <= '0;
            tmo_cnt_q <= '0;
            clk_oe_q  <= 1'b0;
            data_oe_q <= 1'b0;
            busy_q    <= 1'b0;
            done_q    <= 1'b0;
            error_q   <= 1'b0;
        end else begin
            done_q <= 1'b0;
            case (state_q)
                S_IDLE: begin
                    if (tx_start) begin
                        shift_q   <= {~^tx_data, tx_data};
                        error_q   <= 1'b0;
                        busy_q    <= 1'b1;
                        clk_oe_q  <= 1'b1;
                        inh_cnt_q <= '0;
                        state_q   <= S_INHIBIT;
                    end
                end
                S_INHIBIT: begin
                    inh_cnt_q <= inh_cnt_d;
                    if (inh_cnt_q == INH_LAST) begin
                        data_oe_q <= 1'b1;
                        tmo_cnt_q <= '0;
                        state_q   <= S_REQ;
                    end
                end
                S_REQ: begin
                    if (tmo_hit) begin
                        error_q   <= 1'b1;
                        clk_oe_q  <= 1'b0;
                        data_oe_q <= 1'b0;
                        state_q   <= S_DONE;
                    end else begin
                        clk_oe_q  <= 1'b0;
                        bit_cnt_q <= '0;
                        tmo_cnt_q <= tmo_cnt_d;
                        state_q   <= S_SEND;
                    end
                end
                S_SEND: begin
                    if (tmo_hit) begin
                        error_q   <= 1'b1;
                        data_oe_q <= 1'b0;
                        state_q   <= S_DONE;
                    end else if (fall) begin
                        tmo_cnt_q <= '0;
                        bit_cnt_q <= bit_cnt_q + 4'd1;
                        // Falls 1..9 present d0..d7 then parity; fall 10 releases data as the stop bit.
                        if (bit_cnt_q == 4'd9) begin
                            data_oe_q <= 1'b0;
                            state_q   <= S_ACK;
                        end else begin
                            data_oe_q <= ~shift_q[0];
                            shift_q   <= {1'b0, shift_q[8:1]};
                        end
                    end else begin
                        tmo_cnt_q <= tmo_cnt_d;
                    end
                end
                S_ACK: begin
                    if (tmo_hit) begin
                        error_q <= 1'b1;
                        state_q <= S_DONE;
                    end else if (fall) begin
                        error_q   <= data_s;
                        tmo_cnt_q <= '0;
                        state_q   <= S_WAIT_REL;
                    end else begin
                        tmo_cnt_q <= tmo_cnt_d;
                    end
                end
                S_WAIT_REL: begin
                    if (tmo_hit) begin
                        error_q <= 1'b1;
                        state_q <= S_DONE;
                    end else if (clk_s && data_s) begin
                        state_q <= S_DONE;
                    end else begin
                        tmo_cnt_q <= tmo_cnt_d;
                    end
                end
                S_DONE: begin
                    done_q  <= 1'b1;
                    busy_q  <= 1'b0;
                    state_q <= S_IDLE;
                end
                default: begin
                    clk_oe_q  <= 1'b0;
                    data_oe_q <= 1'b0;
                    busy_q    <= 1'b0;
                    state_q   <= S_IDLE;
                end
            endcase
        end
    end

    assign tx_busy     = busy_q;
    assign tx_done     = done_q;
    assign tx_error    = error_q;
    assign ps2_clk_oe  = clk_oe_q;
    assign ps2_data_oe = data_oe_q;

endmodule

// File: tb/tb_ps2_host_tx.sv
// Directed bench for ps2_host_tx: open-collector bus plus a PS/2 device model
// clocking at 40-cycle half periods, with per-scenario inline comparisons.
module tb_ps2_host_tx;

    localparam int INH  = 20;
    localparam int TMO  = 500;
    localparam int HALF = 40;

    logic       clk = 1'b0;
    logic       rst_n = 1'b1;
    logic [7:0] tx_data = 8'h00;
    logic       tx_start = 1'b0;
    logic       tx_busy, tx_done, tx_error;
    logic       clk_oe, data_oe;
    logic       dev_clk_low = 1'b0;
    logic       dev_data_low = 1'b0;
    logic       pad_clk, pad_data;

    int   pass_cnt = 0;
    int   total_cnt = 0;
    int   done_cnt = 0;
    logic last_err = 1'bx;
    logic busy_at_done = 1'bx;

    typedef struct {
        logic       acc_busy;
        logic       acc_clk_oe;
        int         inh;
        int         req;
        bit         req_ok;
        logic       start_held;
        logic [10:0] bits;
        int         dones;
        logic       err;
        logic       busy_at_done;
        logic       idle_after;
    } obs_t;

    assign pad_clk  = ~(clk_oe | dev_clk_low);
    assign pad_data = ~(data_oe | dev_data_low);

    ps2_host_tx #(
        .CLK_HZ        (100_000_000),
        .INHIBIT_CYCLES(INH),
        .TIMEOUT_CYCLES(TMO)
    ) dut (
        .clk        (clk),
        .reset      (rst_n),
        .tx_data    (tx_data),
        .tx_start   (tx_start),
        .tx_busy    (tx_busy),
        .tx_done    (tx_done),
        .tx_error   (tx_error),
        .ps2_clk_in (pad_clk),
        .ps2_data_in(pad_data),
        .ps2_clk_oe (clk_oe),
        .ps2_data_oe(data_oe)
    );

    always #5 clk = ~clk;

    always @(negedge clk) begin
        if (tx_done === 1'b1) begin
            done_cnt     = done_cnt + 1;
            last_err     = tx_error;
            busy_at_done = tx_busy;
        end
    end

    initial begin
        #800_000;
        $display("FAIL watchdog: simulation still running at %0t, expected to have finished", $time);
        $fatal(1);
    end

    // NOTE: stimulus is applied with blocking assignments on the falling edge so it is stable at the next rising edge.
    task automatic start_tx(input logic [7:0] b);
        @(negedge clk);
        tx_data  = b;
        tx_start = 1'b1;
        @(negedge clk);
        tx_start = 1'b0;
    endtask

    task automatic wait_request(output int inh, output int req, output bit ok, output logic start_held);
        inh = 0;
        req = 0;
        ok = 1'b0;
        start_held = 1'bx;
        for (int i = 0; i < 200; i++) begin
            if (data_oe === 1'b1) begin
                ok = 1'b1;
                break;
            end
            if (clk_oe === 1'b1) inh++;
            @(negedge clk);
        end
        if (ok) begin
            ok = 1'b0;
            for (int i = 1; i <= 10; i++) begin
                @(negedge clk);
                if (clk_oe === 1'b0) begin
                    req = i;
                    start_held = data_oe;
                    ok = 1'b1;
                    break;
                end
            end
        end
    endtask

    task automatic device(input bit ack, input int n_clk, input int inject_at, output logic [10:0] bits);
        bits = '1;
        repeat (10) @(negedge clk);
        for (int k = 1; k <= n_clk; k++) begin
            if (ack && k == 11) dev_data_low = 1'b1;
            dev_clk_low = 1'b1;
            if (k == inject_at) begin
                tx_data  = 8'h55;
                tx_start = 1'b1;
                @(negedge clk);
                tx_start = 1'b0;
                repeat (HALF - 1) @(negedge clk);
            end else begin
                repeat (HALF) @(negedge clk);
            end
            dev_clk_low = 1'b0;
            bits[k-1] = pad_data;
            if (k == 11) dev_data_low = 1'b0;
            repeat (HALF) @(negedge clk);
        end
    endtask

    task automatic send_obs(input logic [7:0] b, input bit ack, input int n_clk, input int inject_at,
                            output obs_t o);
        int d0;
        d0 = done_cnt;
        start_tx(b);
        o.acc_busy   = tx_busy;
        o.acc_clk_oe = clk_oe;
        wait_request(o.inh, o.req, o.req_ok, o.start_held);
        o.bits = '1;
        if (o.req_ok) device(ack, n_clk, inject_at, o.bits);
        o.dones        = done_cnt - d0;
        o.err          = last_err;
        o.busy_at_done = busy_at_done;
        o.idle_after   = (clk_oe === 1'b0) && (data_oe === 1'b0) && (tx_busy === 1'b0);
    endtask

    task automatic test_reset();
        #3 rst_n = 1'b0;
        repeat (3) @(negedge clk);
        total_cnt++; if (tx_busy !== 1'b0) $display("FAIL rst_busy: got %b expected 0", tx_busy); else pass_cnt++;
        total_cnt++; if (tx_done !== 1'b0) $display("FAIL rst_done: got %b expected 0", tx_done); else pass_cnt++;
        total_cnt++; if (tx_error !== 1'b0) $display("FAIL rst_error: got %b expected 0", tx_error); else pass_cnt++;
        total_cnt++; if (clk_oe !== 1'b0) $display("FAIL rst_clk_oe: got %b expected 0", clk_oe); else pass_cnt++;
        total_cnt++; if (data_oe !== 1'b0) $display("FAIL rst_data_oe: got %b expected 0", data_oe); else pass_cnt++;
        rst_n = 1'b1;
        repeat (3) @(negedge clk);
    endtask

    task automatic test_send_ed();
        obs_t o;
        send_obs(8'hED, 1'b1, 11, 0, o);
        total_cnt++; if (o.acc_busy !== 1'b1) $display("FAIL ed_busy_after_accept: got %b expected 1", o.acc_busy); else pass_cnt++;
        total_cnt++; if (o.acc_clk_oe !== 1'b1) $display("FAIL ed_clk_oe_after_accept: got %b expected 1", o.acc_clk_oe); else pass_cnt++;
        total_cnt++; if (o.inh !== INH) $display("FAIL ed_inhibit_len: got %0d expected %0d", o.inh, INH); else pass_cnt++;
        total_cnt++; if (o.req !== 1) $display("FAIL ed_req_len: got %0d expected 1", o.req); else pass_cnt++;
        total_cnt++; if (o.start_held !== 1'b1) $display("FAIL ed_start_bit_oe: got %b expected 1", o.start_held); else pass_cnt++;
        total_cnt++; if (o.bits[9:0] !== 10'h3ED) $display("FAIL ed_frame_bits: got %h expected 3ed", o.bits[9:0]); else pass_cnt++;
        total_cnt++; if (o.dones !== 1) $display("FAIL ed_done_pulses: got %0d expected 1", o.dones); else pass_cnt++;
        total_cnt++; if (o.err !== 1'b0) $display("FAIL ed_error: got %b expected 0", o.err); else pass_cnt++;
        total_cnt++; if (o.busy_at_done !== 1'b0) $display("FAIL ed_busy_with_done: got %b expected 0", o.busy_at_done); else pass_cnt++;
        total_cnt++; if (o.idle_after !== 1'b1) $display("FAIL ed_idle_after: got %b expected 1", o.idle_after); else pass_cnt++;
    endtask

    task automatic test_parity();
        obs_t o;
        send_obs(8'h01, 1'b1, 11, 0, o);
        total_cnt++; if (o.bits[9:0] !== 10'h201) $display("FAIL p01_frame_bits: got %h expected 201", o.bits[9:0]); else pass_cnt++;
        total_cnt++; if (o.dones !== 1 || o.err !== 1'b0) $display("FAIL p01_done: got dones=%0d err=%b expected 1/0", o.dones, o.err); else pass_cnt++;
        send_obs(8'hFF, 1'b1, 11, 0, o);
        total_cnt++; if (o.bits[9:0] !== 10'h3FF) $display("FAIL pff_frame_bits: got %h expected 3ff", o.bits[9:0]); else pass_cnt++;
        total_cnt++; if (o.dones !== 1 || o.err !== 1'b0) $display("FAIL pff_done: got dones=%0d err=%b expected 1/0", o.dones, o.err); else pass_cnt++;
    endtask

    task automatic test_no_ack();
        obs_t o;
        send_obs(8'hF3, 1'b0, 11, 0, o);
        total_cnt++; if (o.bits[9:0] !== 10'h3F3) $display("FAIL nack_frame_bits: got %h expected 3f3", o.bits[9:0]); else pass_cnt++;
        total_cnt++; if (o.dones !== 1) $display("FAIL nack_done_pulses: got %0d expected 1", o.dones); else pass_cnt++;
        total_cnt++; if (o.err !== 1'b1) $display("FAIL nack_error: got %b expected 1", o.err); else pass_cnt++;
        total_cnt++; if (o.idle_after !== 1'b1) $display("FAIL nack_bus_released: got %b expected 1", o.idle_after); else pass_cnt++;
        total_cnt++; if (tx_error !== 1'b1) $display("FAIL nack_error_held: got %b expected 1", tx_error); else pass_cnt++;
    endtask

    task automatic test_timeout();
        int inh, req, cyc;
        bit ok, seen;
        logic sh;
        start_tx(8'h12);
        wait_request(inh, req, ok, sh);
        cyc = 0;
        seen = 1'b0;
        for (int i = 0; i < 1000; i++) begin
            @(negedge clk);
            cyc++;
            if (tx_done === 1'b1) begin
                seen = 1'b1;
                break;
            end
        end
        total_cnt++; if (!(ok && seen)) $display("FAIL tmo_done_seen: got req=%0b done=%0b expected 1/1", ok, seen); else pass_cnt++;
        total_cnt++; if (cyc < TMO || cyc > TMO + 5) $display("FAIL tmo_latency: got %0d cycles expected %0d..%0d", cyc, TMO, TMO + 5); else pass_cnt++;
        total_cnt++; if (tx_error !== 1'b1) $display("FAIL tmo_error: got %b expected 1", tx_error); else pass_cnt++;
        total_cnt++; if (clk_oe !== 1'b0 || data_oe !== 1'b0) $display("FAIL tmo_oe: got clk_oe=%b data_oe=%b expected 0/0", clk_oe, data_oe); else pass_cnt++;
        total_cnt++; if (tx_busy !== 1'b0) $display("FAIL tmo_busy: got %b expected 0", tx_busy); else pass_cnt++;
        repeat (5) @(negedge clk);
    endtask

    task automatic test_busy_ignore();
        obs_t o;
        send_obs(8'h3C, 1'b1, 11, 5, o);
        total_cnt++; if (o.bits[9:0] !== 10'h33C) $display("FAIL ign_frame_bits: got %h expected 33c", o.bits[9:0]); else pass_cnt++;
        total_cnt++; if (o.dones !== 1 || o.err !== 1'b0) $display("FAIL ign_done: got dones=%0d err=%b expected 1/0", o.dones, o.err); else pass_cnt++;
        repeat (30) @(negedge clk);
        total_cnt++; if (tx_busy !== 1'b0 || clk_oe !== 1'b0) $display("FAIL ign_not_queued: got busy=%b clk_oe=%b expected 0/0", tx_busy, clk_oe); else pass_cnt++;
    endtask

    task automatic test_reset_mid_frame();
        obs_t o;
        int d0;
        send_obs(8'hA5, 1'b1, 4, 0, o);
        d0 = done_cnt;
        total_cnt++; if (data_oe !== 1'b1 || tx_busy !== 1'b1) $display("FAIL mid_pre_reset: got data_oe=%b busy=%b expected 1/1", data_oe, tx_busy); else pass_cnt++;
        rst_n = 1'b0;
        #1;
        total_cnt++; if (clk_oe !== 1'b0 || data_oe !== 1'b0) $display("FAIL mid_async_oe: got clk_oe=%b data_oe=%b expected 0/0", clk_oe, data_oe); else pass_cnt++;
        total_cnt++; if (tx_busy !== 1'b0) $display("FAIL mid_async_busy: got %b expected 0", tx_busy); else pass_cnt++;
        repeat (3) @(negedge clk);
        rst_n = 1'b1;
        repeat (50) @(negedge clk);
        total_cnt++; if (done_cnt !== d0) $display("FAIL mid_no_done: got %0d pulses expected 0", done_cnt - d0); else pass_cnt++;
        send_obs(8'hF4, 1'b1, 11, 0, o);
        total_cnt++; if (o.bits[9:0] !== 10'h2F4) $display("FAIL f4_frame_bits: got %h expected 2f4", o.bits[9:0]); else pass_cnt++;
        total_cnt++; if (o.dones !== 1 || o.err !== 1'b0) $display("FAIL f4_done: got dones=%0d err=%b expected 1/0", o.dones, o.err); else pass_cnt++;
    endtask

    initial begin
        test_reset();
        test_send_ed();
        test_parity();
        test_no_ack();
        test_timeout();
        test_busy_ignore();
        test_reset_mid_frame();
        $display("%0d/%0d checks passed", pass_cnt, total_cnt);
        $finish;
    end

endmodule
